// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback sources.
// The winning beat is registered one cycle before it reaches the register file.
module rf_wb_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned CW   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [DW-1:0]      rf_wdata,
    input  logic [AW-1:0]      byp_raddr1,
    input  logic [AW-1:0]      byp_raddr2,
    output logic               byp_hit1,
    output logic               byp_hit2,
    output logic [CW-1:0]      contention_cnt
);

    localparam int unsigned PW     = $clog2(NREQ);
    localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

    logic [AW-1:0] addr_arr [NREQ];
    logic [DW-1:0] data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*AW +: AW];
        assign data_arr[i] = req_data[i*DW +: DW];
    end

    logic [PW-1:0] ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [PW-1:0] gnt_idx;
    logic [PW:0]   cand;
    logic [PW:0]   ptr_nxt;
    logic          found;
    logic          multi;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // Scan ptr, ptr+1, ... modulo NREQ; first valid source wins.
    always_comb begin
        req_ready = '0;
        gnt_idx   = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (en && !found && req_valid[cand[PW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[PW-1:0];
            end
        end
        if (found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign sel_addr = addr_arr[gnt_idx];
    assign sel_data = data_arr[gnt_idx];

    // Two or more bits set iff clearing the lowest set bit leaves something.
    assign multi = |(req_valid & (req_valid - NREQ'(1)));

    always_comb begin
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        ptr_nxt = {1'b0, gnt_idx} + (PW+1)'(1);
        if (found) begin
            ptr_d = (ptr_nxt >= NREQ_W) ? '0 : ptr_nxt[PW-1:0];
            // Writes to r0 are consumed but never reach the register file.
            if (sel_addr != '0) begin
                we_d    = 1'b1;
                waddr_d = sel_addr;
                wdata_d = sel_data;
            end
        end
        if (en && multi && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rf_we          = we_q;
    assign rf_waddr       = waddr_q;
    assign rf_wdata       = wdata_q;
    assign contention_cnt = cnt_q;

    assign byp_hit1 = we_q && (waddr_q == byp_raddr1) && (byp_raddr1 != '0);
    assign byp_hit2 = we_q && (waddr_q == byp_raddr2) && (byp_raddr2 != '0);

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the single register-file write port (we/waddr/wdata) among NREQ writeback sources, e.g. ALU, load unit and multiply/divide unit. Arbitration is round-robin with a valid/ready handshake per source. The winning write is registered and driven to the register file one cycle later. The block also offers a read-bypass compare against the in-flight write and a saturating contention counter for debug.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
DW, 32, data width
AW, 5, register address width
CW, 16, contention counter width

Ports:
clk  input  1  clock
rst  input  1  reset
en  input  1  arbitration enable; 0 = freeze (pipeline stall)
req_valid  input  NREQ  per-source write request
req_addr  input  NREQ*AW  per-source destination; source i occupies bits [i*AW +: AW]
req_data  input  NREQ*DW  per-source data; source i occupies bits [i*DW +: DW]
req_ready  output  NREQ  one-hot grant; a beat transfers when valid & ready
rf_we  output  1  register-file write enable
rf_waddr  output  AW  register-file write address
rf_wdata  output  DW  register-file write data
byp_raddr1  input  AW  read address 1 for the bypass check
byp_raddr2  input  AW  read address 2 for the bypass check
byp_hit1  output  1  rf_we & (rf_waddr==byp_raddr1) & (byp_raddr1!=0)
byp_hit2  output  1  same check for byp_raddr2
contention_cnt  output  CW  count of cycles with en=1 and 2 or more req_valid

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk.
  - Reset clears rf_we, rf_waddr, rf_wdata, contention_cnt and the round-robin pointer ptr to 0.
  - req_ready is combinational, so it is 0 while no request is valid.
  - Reset asserted mid-operation drops any in-flight registered write; no write reaches the register file.
- Arbitration is combinational in the same cycle:
  - If en=1 and req_valid!=0, grant the first valid source scanning ptr, ptr+1, …, wrapping modulo NREQ.
  - req_ready is one-hot on that source and 0 on all others.
  - If en=0 or no source is valid, req_ready=0.
  - req_ready must not depend on req_addr or req_data.
- Pointer update: on an accepted beat, ptr <= (granted index + 1) mod NREQ. Otherwise ptr holds.
- Output register: latency from accept edge to rf_we high is exactly 1 cycle.
  - Accept with req_addr!=0: rf_we<=1; rf_waddr/rf_wdata <= the granted source's addr/data.
  - Accept with req_addr==0: the beat is consumed (ready=1) but rf_we<=0, so writes to r0 are discarded.
  - No accept (including en=0): rf_we<=0; rf_waddr/rf_wdata hold their values.
  - Throughput is one write per cycle; back-to-back accepts give consecutive rf_we pulses.
- Sources must hold valid/addr/data stable until accepted. The arbiter is not required to handle withdrawn requests.
- Bypass outputs are purely combinational from the output register and byp_raddr*. Address 0 never hits.
- contention_cnt increments on each cycle with en=1 and popcount(req_valid)>=2. It saturates at all-ones and never wraps.
- Single requester: it is granted every cycle it is valid, regardless of ptr.

Test Plan:
- Reset check: assert rst mid-stream with rf_we=1 -> rf_we=0, contention_cnt=0, ptr=0 immediately; after release, source 0 wins first when all sources are valid.
- Round-robin fairness: all 3 sources valid continuously, addrs 1/2/3, data A/B/C -> grants 0,1,2,0,1,2; rf_waddr sequence 1,2,3,1,… one cycle after each grant; contention_cnt +1 per cycle.
- R0 discard: source 1 only, addr 0, data 0xDEADBEEF -> req_ready[1]=1 for 1 cycle; next cycle rf_we=0; ptr advances to 2.
- Stall: en=0 for 3 cycles with all sources valid -> req_ready=0, rf_we=0, rf_waddr/wdata held, contention_cnt unchanged; en=1 -> arbitration resumes from the held ptr.
- Bypass: source 2 writes addr 7, data 0x12345678; next cycle byp_raddr1=7 and byp_raddr2=0 -> byp_hit1=1, byp_hit2=0; one cycle later byp_hit1=0.
- Saturation: CW=4, all sources valid for 20 cycles -> contention_cnt stops at 15.
